// File: rtl/lsu_mem_if.sv
// lsu_mem_if -- load/store front end for a word-addressed single-port data
// memory (2**ADDR_W x 32, registered read data).
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend (1) or sign-extend (0) sub-word loads
//   req_addr          byte address
//   req_wdata         right-justified store data
//   rsp_valid/ready   response handshake
//   rsp_rdata         extended load result (0 for stores and errors)
//   rsp_err           misaligned, illegal-size or out-of-window request
//   mem_CEN/WEN/BWEN  memory enable, write-not (0 = write), per-bit write mask
//   mem_A/D           memory word address and write data
//   mem_Q             memory read data, valid the cycle after the read edge
//
// One request is in flight at a time: IDLE -> ACCESS -> (CAPTURE) -> RESP.
// Failed checks skip the memory entirely and go straight to RESP.
module lsu_mem_if #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CHECK_RANGE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_CEN,
  output logic              mem_WEN,
  output logic [31:0]       mem_BWEN,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_D,
  input  logic [31:0]       mem_Q
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t state_q;

  // Request registers. Only the byte offset of the address is needed after
  // the access has been launched, so only that part is kept.
  logic       we_q;
  logic [1:0] size_q;
  logic       unsigned_q;
  logic [1:0] off_q;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              mem_cen_q;
  logic              mem_wen_q;
  logic [31:0]       mem_bwen_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [31:0]       mem_d_q;

  // Address relative to the memory window; BASE_ADDR is word aligned, so the
  // low two bits equal the byte offset of the original address.
  logic [31:0] rel_addr;
  logic        misaligned;
  logic        illegal_size;
  logic        out_of_range;
  logic        req_bad;
  logic [31:0] bwen_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] rdata_d;

  generate
    if ((CHECK_RANGE != 0) && (ADDR_W + 2 < 32)) begin : g_range
      assign out_of_range = |rel_addr[31:ADDR_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    rel_addr     = req_addr - BASE_ADDR;
    misaligned   = ((req_size == 2'b01) && rel_addr[0]) ||
                   ((req_size == 2'b10) && (rel_addr[1:0] != 2'b00));
    illegal_size = (req_size == 2'b11);
    req_bad      = misaligned || illegal_size || out_of_range;

    // Lane mask and lane-aligned store data. Bytes outside the mask are 0.
    case (req_size)
      2'b00: begin
        bwen_d  = 32'h0000_00FF << {rel_addr[1:0], 3'b000};
        wdata_d = {24'b0, req_wdata[7:0]} << {rel_addr[1:0], 3'b000};
      end
      2'b01: begin
        bwen_d  = 32'h0000_FFFF << {rel_addr[1], 4'b0000};
        wdata_d = {16'b0, req_wdata[15:0]} << {rel_addr[1], 4'b0000};
      end
      default: begin
        bwen_d  = 32'hFFFF_FFFF;
        wdata_d = req_wdata;
      end
    endcase

    // Read-lane selection and extension from the registered memory output.
    case (off_q)
      2'b00:   byte_lane = mem_Q[7:0];
      2'b01:   byte_lane = mem_Q[15:8];
      2'b10:   byte_lane = mem_Q[23:16];
      default: byte_lane = mem_Q[31:24];
    endcase
    half_lane = off_q[1] ? mem_Q[31:16] : mem_Q[15:0];

    case (size_q)
      2'b00:   rdata_d = {{24{byte_lane[7] & ~unsigned_q}}, byte_lane};
      2'b01:   rdata_d = {{16{half_lane[15] & ~unsigned_q}}, half_lane};
      default: rdata_d = mem_Q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      off_q       <= 2'b00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_cen_q   <= 1'b0;
      mem_wen_q   <= 1'b1;
      mem_bwen_q  <= 32'h0;
      mem_a_q     <= '0;
      mem_d_q     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            unsigned_q  <= req_unsigned;
            off_q       <= rel_addr[1:0];
            req_ready_q <= 1'b0;
            if (req_bad) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              // Memory controls are registered here so they are present for
              // exactly the ACCESS cycle.
              state_q    <= ACCESS;
              mem_cen_q  <= 1'b1;
              mem_wen_q  <= ~req_we;
              mem_a_q    <= rel_addr[ADDR_W+1:2];
              mem_bwen_q <= req_we ? bwen_d  : 32'h0;
              mem_d_q    <= req_we ? wdata_d : 32'h0;
            end
          end
        end
        ACCESS: begin
          mem_cen_q  <= 1'b0;
          mem_wen_q  <= 1'b1;
          mem_bwen_q <= 32'h0;
          mem_a_q    <= '0;
          mem_d_q    <= 32'h0;
          if (we_q) begin
            // The write is committed by the memory on this edge.
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= rdata_d;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_CEN   = mem_cen_q;
  assign mem_WEN   = mem_wen_q;
  assign mem_BWEN  = mem_bwen_q;
  assign mem_A     = mem_a_q;
  assign mem_D     = mem_d_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: a 1024x32 bit-masked memory with registered read,
// a byte-level reference model checked on every cycle, and directed
// transactions with hand-computed expected results.
module tb_lsu_mem_if;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_CEN;
  logic        mem_WEN;
  logic [31:0] mem_BWEN;
  logic [9:0]  mem_A;
  logic [31:0] mem_D;
  logic [31:0] mem_Q = 32'h0;

  lsu_mem_if dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_CEN(mem_CEN), .mem_WEN(mem_WEN), .mem_BWEN(mem_BWEN),
    .mem_A(mem_A), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory attached to the DUT pins.
  logic [31:0] ram [0:1023];
  always @(posedge CLK) begin
    if (mem_CEN) begin
      if (!mem_WEN) ram[mem_A] <= (ram[mem_A] & ~mem_BWEN) | (mem_D & mem_BWEN);
      else          mem_Q <= ram[mem_A];
    end
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 1)         return 32'h1234_5678;
    else if (i == 1023) return 32'hCAFE_F00D;
    else                return (32'(i) * 32'h0001_0001) ^ 32'h0F0F_0000;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = init_word(i);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed) ----------------
  logic [7:0]  gold [0:4095];
  logic        pend = 1'b0;
  int          p_acc, p_lat;
  logic        p_err, p_we;
  logic [31:0] p_rdata, p_bwen, p_d, p_a;

  // Observed memory activity, used by the directed checks.
  int          cen_count = 0;
  logic [31:0] snap_a, snap_bwen, snap_d, snap_wen;

  task automatic model_accept();
    logic [31:0] rel, v, low;
    int nb, off;
    rel   = req_addr - 32'h0;
    nb    = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
    off   = int'(rel % 4);
    p_err = (req_size == 2'd3) || (req_size == 2'd1 && (req_addr % 2) != 0) ||
            (req_size == 2'd2 && (req_addr % 4) != 0) || (rel >= 32'd4096);
    p_we  = req_we;
    p_acc = cyc + 1;
    p_lat = p_err ? 0 : (req_we ? 1 : 2);
    p_a   = rel / 4;
    p_bwen = 32'h0; p_d = 32'h0; p_rdata = 32'h0;
    if (!p_err && req_we) begin
      for (int k = 0; k < nb; k++) begin
        p_bwen = p_bwen | (32'hFF << (8 * (off + k)));
        p_d    = p_d | (((req_wdata >> (8 * k)) & 32'hFF) << (8 * (off + k)));
        gold[int'(rel) + k] = req_wdata[8*k +: 8];
      end
    end else if (!p_err) begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(gold[int'(rel) + k]) << (8 * k));
      if (nb < 4) begin
        low = (32'd1 << (8 * nb)) - 32'd1;
        if (!req_unsigned && v[8*nb-1]) v = v | ~low;
      end
      p_rdata = v;
    end
    pend = 1'b1;
  endtask

  task automatic mon_step();
    logic exp_ready, exp_valid, exp_cen;
    exp_ready = !pend;
    exp_valid = pend && (cyc >= p_acc + p_lat);
    exp_cen   = pend && !p_err && (cyc == p_acc);
    chk("mon_req_ready", 32'(req_ready), 32'(exp_ready));
    chk("mon_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    chk("mon_mem_CEN",   32'(mem_CEN),   32'(exp_cen));
    chk("mon_mem_WEN",   32'(mem_WEN),   exp_cen ? 32'(!p_we) : 32'd1);
    chk("mon_mem_A",     32'(mem_A),     exp_cen ? p_a : 32'd0);
    chk("mon_mem_BWEN",  mem_BWEN,       exp_cen ? p_bwen : 32'd0);
    chk("mon_mem_D",     mem_D,          exp_cen ? p_d : 32'd0);
    if (exp_valid) begin
      chk("mon_rsp_err",   32'(rsp_err), 32'(p_err));
      chk("mon_rsp_rdata", rsp_rdata,    (p_err || p_we) ? 32'd0 : p_rdata);
    end
    if (mem_CEN) begin
      cen_count++;
      snap_a = 32'(mem_A); snap_bwen = mem_BWEN; snap_d = mem_D; snap_wen = 32'(mem_WEN);
    end
    if (RST)                        pend = 1'b0;
    else if (pend)                  begin if (exp_valid && rsp_ready) pend = 1'b0; end
    else if (req_valid)             model_accept();
  endtask

  // ---------------- stimulus helpers ----------------
  int          acc_cyc;
  logic [31:0] rd_v;
  logic        er_v;
  int          lat_v;
  int          cen_before;

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  // Ends on the negedge where rsp_valid is first seen.
  task automatic wait_rsp();
    bit ok;
    ok = 0; rd_v = 32'hX; er_v = 1'bX; lat_v = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        ok = 1; rd_v = rsp_rdata; er_v = rsp_err; lat_v = cyc - acc_cyc + 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    issue(we, sz, uns, addr, wd);
    wait_rsp();
    @(posedge CLK); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int k = 0; k < 4; k++) gold[4*i + k] = w[8*k +: 8];
    end
    @(posedge CLK); #1;
    fork
      forever begin
        @(negedge CLK);
        mon_step();
      end
    join_none
    @(negedge CLK);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_mem_WEN",   32'(mem_WEN), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Store byte 0xAB to address 5.
    txn(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB);
    chk("sb_lat",  32'(lat_v), 32'd2);
    chk("sb_err",  32'(er_v),  32'd0);
    chk("sb_A",    snap_a,     32'd1);
    chk("sb_BWEN", snap_bwen,  32'h0000_FF00);
    chk("sb_D",    snap_d,     32'h0000_AB00);
    chk("sb_WEN",  snap_wen,   32'd0);

    // Word 1 is now 0x1234AB78.
    txn(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    chk("lb_s_data", rd_v, 32'hFFFF_FFAB);
    chk("lb_s_lat",  32'(lat_v), 32'd3);
    txn(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
    chk("lb_u_data", rd_v, 32'h0000_00AB);
    txn(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    chk("lh_s6_data", rd_v, 32'h0000_1234);
    txn(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
    chk("lh_s4_data", rd_v, 32'hFFFF_AB78);
    txn(1'b0, 2'b10, 1'b1, 32'h4, 32'h0);
    chk("lw_data", rd_v, 32'h1234_AB78);

    // Upper-half store into word 0 (initially 0x0F0F0000).
    txn(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF);
    chk("sh_BWEN", snap_bwen, 32'hFFFF_0000);
    chk("sh_D",    snap_d,    32'hBEEF_0000);
    txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("sh_readback", rd_v, 32'hBEEF_0000);

    // Error cases never touch memory.
    cen_before = cen_count;
    txn(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    chk("err_lh3_err", 32'(er_v), 32'd1);
    chk("err_lh3_lat", 32'(lat_v), 32'd1);
    chk("err_lh3_rdata", rd_v, 32'd0);
    txn(1'b1, 2'b10, 1'b0, 32'h2, 32'h1111_2222);
    chk("err_sw2_err", 32'(er_v), 32'd1);
    txn(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("err_size_err", 32'(er_v), 32'd1);
    txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    chk("err_range_err", 32'(er_v), 32'd1);
    chk("err_range_lat", 32'(lat_v), 32'd1);
    chk("err_no_cen", 32'(cen_count), 32'(cen_before));

    // Last word of the window.
    txn(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    chk("top_A", snap_a, 32'h3FF);
    chk("top_err", 32'(er_v), 32'd0);
    chk("top_data", rd_v, 32'hCAFE_F00D);

    // Back-pressure: response held while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    wait_rsp();
    chk("hold_first", rd_v, 32'h0000_0012);
    cen_before = cen_count;
    repeat (4) begin
      @(posedge CLK); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
      @(negedge CLK);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'h0000_0012);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
    chk("hold_no_cen", 32'(cen_count), 32'(cen_before));

    // Reset while in CAPTURE: response dropped.
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_cap_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cap_ready", 32'(req_ready), 32'd1);
    chk("rst_cap_cen",   32'(mem_CEN),   32'd0);
    repeat (3) @(negedge CLK);
    chk("rst_cap_no_reissue", 32'(rsp_valid), 32'd0);

    // Reset while in ACCESS of a store: the write still lands.
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    txn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("rst_acc_store_kept", rd_v, 32'hDEAD_BEEF);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
